// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the core's single interrupt input.
// Synchronises, edge-detects, latches and prioritises external requests.
module irq_ctrl #(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int VEC_W       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ps_msk_wrt_en,
    input  logic [NUM_IRQ-1:0] ps_msk_dt,
    input  logic               ps_irq_ack,
    input  logic               ps_irq_done,
    output logic               interrupt,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [NUM_IRQ-1:0] irq_pend,
    output logic               irq_actv
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t state;
    state_t state_n;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] hist;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] elig;
    logic [VEC_W-1:0]   win;
    logic               int_n;
    logic [VEC_W-1:0]   vec_n;
    logic               actv_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist;

    always_comb begin
        clr = '0;
        if (state == REQ && ps_irq_ack) begin
            clr[irq_vec] = 1'b1;
        end
    end

    // A fresh edge overrides the ack-clear so no request is ever dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pend <= '0;
            mask     <= '0;
        end else begin
            irq_pend <= (irq_pend & ~clr) | rise;
            if (ps_msk_wrt_en) begin
                mask <= ps_msk_dt;
            end
        end
    end

    assign elig = irq_pend & mask;

    always_comb begin
        win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = VEC_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            irq_vec   <= '0;
            irq_actv  <= 1'b0;
        end else begin
            state     <= state_n;
            interrupt <= int_n;
            irq_vec   <= vec_n;
            irq_actv  <= actv_n;
        end
    end

    always_comb begin
        state_n = state;
        int_n   = interrupt;
        vec_n   = irq_vec;
        actv_n  = irq_actv;
        unique case (state)
            IDLE: begin
                if (|elig) begin
                    vec_n   = win;
                    int_n   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ps_irq_ack) begin
                    int_n   = 1'b0;
                    actv_n  = 1'b1;
                    state_n = SERVICE;
                end
            end
            SERVICE: begin
                if (ps_irq_done) begin
                    actv_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                int_n   = 1'b0;
                actv_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a queue of expected vectors
// checked whenever the controller raises interrupt.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq_in = '0;
    logic       ps_msk_wrt_en = 1'b0;
    logic [3:0] ps_msk_dt = '0;
    logic       ps_irq_ack = 1'b0;
    logic       ps_irq_done = 1'b0;
    logic       interrupt;
    logic [1:0] irq_vec;
    logic [3:0] irq_pend;
    logic       irq_actv;

    int tests = 0;
    int fails = 0;
    logic [1:0] exp_q[$];

    irq_ctrl #(
        .NUM_IRQ    (4),
        .SYNC_STAGES(2),
        .VEC_W      (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .ps_msk_wrt_en(ps_msk_wrt_en),
        .ps_msk_dt    (ps_msk_dt),
        .ps_irq_ack   (ps_irq_ack),
        .ps_irq_done  (ps_irq_done),
        .interrupt    (interrupt),
        .irq_vec      (irq_vec),
        .irq_pend     (irq_pend),
        .irq_actv     (irq_actv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_mask(input logic [3:0] m);
        ps_msk_wrt_en = 1'b1;
        ps_msk_dt     = m;
        step(1);
        ps_msk_wrt_en = 1'b0;
    endtask

    task automatic pop_vec(input string tag);
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed vec %0d expected none queued", tag, irq_vec);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(irq_vec), 32'(e));
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!interrupt && n < budget) begin
            step(1);
            n++;
        end
        if (!interrupt) begin
            tests++;
            fails++;
            $error("FAIL %s: observed timeout expected interrupt", tag);
        end else begin
            pop_vec(tag);
        end
    endtask

    task automatic ack();
        ps_irq_ack = 1'b1;
        step(1);
        ps_irq_ack = 1'b0;
    endtask

    task automatic done();
        ps_irq_done = 1'b1;
        step(1);
        ps_irq_done = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_int", 32'(interrupt), 0);
        chk("rst_pend", 32'(irq_pend), 0);
        chk("rst_actv", 32'(irq_actv), 0);
        chk("rst_vec", 32'(irq_vec), 0);
        step(2);
        reset = 1'b1;

        // Single source latency and full handshake
        wr_mask(4'b1111);
        irq_in[2] = 1'b1;
        exp_q.push_back(2'd2);
        step(3);
        irq_in[2] = 1'b0;
        chk("t1_pend_e3", 32'(irq_pend), 32'h4);
        chk("t1_int_e3", 32'(interrupt), 0);
        step(1);
        chk("t1_int_e4", 32'(interrupt), 1);
        pop_vec("t1_vec");
        ack();
        chk("t1_ack_int", 32'(interrupt), 0);
        chk("t1_ack_actv", 32'(irq_actv), 1);
        chk("t1_ack_pend", 32'(irq_pend), 0);
        done();
        chk("t1_done_actv", 32'(irq_actv), 0);
        step(1);
        chk("t1_idle_int", 32'(interrupt), 0);

        // Simultaneous sources, lowest index first
        irq_in[3] = 1'b1;
        irq_in[1] = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        wait_req("t2_first", 10);
        ack();
        done();
        chk("t2_gap_int", 32'(interrupt), 0);
        step(1);
        chk("t2_second_int", 32'(interrupt), 1);
        pop_vec("t2_second_vec");
        ack();
        done();
        irq_in = '0;
        step(2);

        // Masked source presented after unmask
        wr_mask(4'b1011);
        irq_in[2] = 1'b1;
        step(6);
        chk("t3_pend", 32'(irq_pend), 32'h4);
        chk("t3_masked_int", 32'(interrupt), 0);
        ps_msk_wrt_en = 1'b1;
        ps_msk_dt     = 4'b1111;
        exp_q.push_back(2'd2);
        step(1);
        ps_msk_wrt_en = 1'b0;
        chk("t3_w1_int", 32'(interrupt), 0);
        step(1);
        chk("t3_w2_int", 32'(interrupt), 1);
        pop_vec("t3_vec");
        irq_in[2] = 1'b0;

        // Mask change in REQ; new edge coincident with ack
        wr_mask(4'b0000);
        chk("t4_hold_int", 32'(interrupt), 1);
        chk("t4_hold_vec", 32'(irq_vec), 2);
        wr_mask(4'b1111);
        step(2);
        irq_in[2] = 1'b1;
        step(2);
        ps_irq_ack = 1'b1;
        step(1);
        ps_irq_ack = 1'b0;
        chk("t4_pend_kept", 32'(irq_pend), 32'h4);
        chk("t4_actv", 32'(irq_actv), 1);
        exp_q.push_back(2'd2);
        done();
        chk("t4_done_actv", 32'(irq_actv), 0);
        step(1);
        chk("t4_again_int", 32'(interrupt), 1);
        pop_vec("t4_again_vec");
        ack();
        done();
        irq_in[2] = 1'b0;

        // Out-of-state handshakes and held-high line
        irq_in[0] = 1'b1;
        exp_q.push_back(2'd0);
        wait_req("t5_req", 10);
        done();
        chk("t5_done_in_req_int", 32'(interrupt), 1);
        chk("t5_done_in_req_actv", 32'(irq_actv), 0);
        ack();
        chk("t5_svc_actv", 32'(irq_actv), 1);
        ack();
        chk("t5_ack_in_svc_actv", 32'(irq_actv), 1);
        chk("t5_ack_in_svc_int", 32'(interrupt), 0);
        done();
        step(8);
        chk("t5_single_int", 32'(interrupt), 0);
        chk("t5_single_pend", 32'(irq_pend), 0);

        // Ack and done together in REQ, then async reset in SERVICE
        irq_in[2] = 1'b1;
        exp_q.push_back(2'd2);
        wait_req("t6_req", 10);
        ps_irq_ack  = 1'b1;
        ps_irq_done = 1'b1;
        step(1);
        ps_irq_ack  = 1'b0;
        ps_irq_done = 1'b0;
        chk("t6_both_actv", 32'(irq_actv), 1);
        irq_in[1] = 1'b1;
        irq_in[3] = 1'b1;
        step(4);
        chk("t6_svc_actv", 32'(irq_actv), 1);
        chk("t6_pend", 32'(irq_pend), 32'hA);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_int", 32'(interrupt), 0);
        chk("t6_rst_actv", 32'(irq_actv), 0);
        chk("t6_rst_pend", 32'(irq_pend), 0);
        chk("t6_rst_vec", 32'(irq_vec), 0);
        @(negedge clk);
        reset = 1'b1;
        step(10);
        chk("t6_post_int", 32'(interrupt), 0);
        chk("t6_post_actv", 32'(irq_actv), 0);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
